// File: rtl/ram2e_phase.sv
// ram2e_phase: tracks the Apple II PHI0 bus phase on C14M, locks onto 14/16-clock cycles, issues refresh ticks.
// Define RAM2E_LONGCYC_CHECK_EN to also require one long cycle after every 64 short cycles while locked.
module ram2e_phase #(
    parameter int ACQ_CNT = 4,
    parameter int REF_DIV = 13
) (
    input  logic       C14M,
    input  logic       nRST,
    input  logic       PHI0,
    output logic [3:0] Phase,
    output logic       CycStart,
    output logic       LongCyc,
    output logic       Locked,
    output logic       RefTick,
    output logic       SeqErr,
    output logic [3:0] ErrCnt
);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
    localparam int AW = $clog2(ACQ_CNT + 1);
    localparam int RW = $clog2(REF_DIV + 1);
    state_t state_q, state_d;
    logic p0d_q, hold_q, hold_d, cyc_start_q, long_cyc_q, long_cyc_d;
    logic locked_q, locked_d, ref_tick_q, ref_tick_d, seq_err_q, seq_err_d;
    logic [3:0] phase_q, phase_d, err_cnt_q, err_cnt_d;
    logic [AW-1:0] acq_q, acq_d;
    logic [RW-1:0] ref_q, ref_d;
    logic rise, len_ok, is_long, stuck, bad, lc_err, cnt_run;
    logic [4:0] len;
    assign rise    = PHI0 & ~p0d_q;
    assign len     = {1'b0, phase_q} + 5'd1;
    assign len_ok  = (len == 5'd14) || (len == 5'd16);
    assign is_long = len == 5'd16;
    assign stuck   = (phase_q == 4'd15) && !rise;
    // an overflow counts once; hold_q masks the following clocks stuck at 15
    assign bad     = (rise && (!len_ok || lc_err)) || (stuck && !hold_q);
`ifdef RAM2E_LONGCYC_CHECK_EN
    logic [6:0] lc_cnt_q, lc_cnt_d;
    logic lc_sync_q, lc_sync_d;
    // until the first long cycle after lock the alignment is unknown, so only the 65-short limit applies
    assign lc_err = (state_q == LOCKED) && rise && len_ok &&
                    (is_long ? (lc_sync_q && lc_cnt_q != 7'd64) : (lc_cnt_q == 7'd64));
    always_comb begin
        lc_cnt_d  = lc_cnt_q;
        lc_sync_d = lc_sync_q;
        if (state_q != LOCKED || state_d != LOCKED) begin
            lc_cnt_d  = '0;
            lc_sync_d = 1'b0;
        end else if (rise && len_ok) begin
            lc_cnt_d  = is_long ? 7'd0 : lc_cnt_q + 7'd1;
            lc_sync_d = lc_sync_q | is_long;
        end
    end
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            lc_cnt_q  <= '0;
            lc_sync_q <= 1'b0;
        end else begin
            lc_cnt_q  <= lc_cnt_d;
            lc_sync_q <= lc_sync_d;
        end
    end
`else
    assign lc_err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        acq_d   = acq_q;
        unique case (state_q)
            UNLOCKED: if (rise) begin
                state_d = ACQUIRE;
                acq_d   = '0;
            end
            ACQUIRE: if (bad) state_d = UNLOCKED;
                else if (rise) begin
                    acq_d   = acq_q + AW'(1);
                    state_d = (acq_q == AW'(ACQ_CNT - 1)) ? LOCKED : ACQUIRE;
                end
            LOCKED: if (bad) state_d = UNLOCKED;
            default: state_d = UNLOCKED;
        endcase
    end
    always_comb begin
        phase_d    = rise ? 4'd0 : (phase_q == 4'd15 ? phase_q : phase_q + 4'd1);
        hold_d     = stuck;
        long_cyc_d = (rise && len_ok) ? is_long : long_cyc_q;
        locked_d   = state_d == LOCKED;
        seq_err_d  = (state_q == LOCKED) && bad;
        err_cnt_d  = (seq_err_d && err_cnt_q != 4'd15) ? err_cnt_q + 4'd1 : err_cnt_q;
        cnt_run    = (state_q == LOCKED) && locked_d && rise;
        ref_tick_d = cnt_run && (ref_q == RW'(REF_DIV - 1));
        ref_d      = !locked_d ? '0 : (ref_tick_d ? '0 : (cnt_run ? ref_q + RW'(1) : ref_q));
    end
    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            state_q     <= UNLOCKED;
            p0d_q       <= 1'b1;
            hold_q      <= 1'b0;
            phase_q     <= '0;
            cyc_start_q <= 1'b0;
            long_cyc_q  <= 1'b0;
            locked_q    <= 1'b0;
            ref_tick_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            acq_q       <= '0;
            ref_q       <= '0;
        end else begin
            state_q     <= state_d;
            p0d_q       <= PHI0;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            cyc_start_q <= rise;
            long_cyc_q  <= long_cyc_d;
            locked_q    <= locked_d;
            ref_tick_q  <= ref_tick_d;
            seq_err_q   <= seq_err_d;
            err_cnt_q   <= err_cnt_d;
            acq_q       <= acq_d;
            ref_q       <= ref_d;
        end
    end
    assign Phase    = phase_q;
    assign CycStart = cyc_start_q;
    assign LongCyc  = long_cyc_q;
    assign Locked   = locked_q;
    assign RefTick  = ref_tick_q;
    assign SeqErr   = seq_err_q;
    assign ErrCnt   = err_cnt_q;
endmodule
